// File: rtl/fpu_wb_pkg.sv
// Shared types and helpers for the FPU writeback arbiter (RV64D: FLEN=64, fmt 0=single, 1=double).
package fpu_wb_pkg;

  localparam int FLEN    = 64;
  localparam int FMTBITS = 1;
  localparam int RDW     = 5;
  localparam int NFLAGS  = 5;
  localparam int PTRW    = 2;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  localparam logic [FMTBITS-1:0] FMT_S = 1'b0;
  localparam logic [FMTBITS-1:0] FMT_D = 1'b1;

  typedef struct packed {
    logic [FLEN-1:0]   data;
    logic [RDW-1:0]    rd;
    logic [PTRW-1:0]   src;
    logic [NFLAGS-1:0] flags;
  } wb_entry_t;

  function automatic logic [PTRW-1:0] rr_next(input logic [PTRW-1:0] ptr, input int unsigned n);
    if (32'(ptr) + 32'd1 >= n) return '0;
    return ptr + PTRW'(1);
  endfunction

  // Single results are carried in double layout; repack to binary32 and NaN-box.
  function automatic logic [FLEN-1:0] fp_pack(input logic [FLEN-1:0] r, input logic [FMTBITS-1:0] fmt);
    if (fmt == FMT_D) return r;
    return {32'hFFFF_FFFF, r[63], r[62], r[58:52], r[51:29]};
  endfunction

endpackage

// File: rtl/fpu_wb_arbiter_if.sv
// Producer-side request bundle and writeback-side output bundle of the arbiter.
interface fpu_wb_arbiter_if import fpu_wb_pkg::*; #(parameter int NREQ = 3);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*FLEN-1:0]    req_result;
  logic [NREQ*FMTBITS-1:0] req_fmt;
  logic [NREQ*RDW-1:0]     req_rd;
  logic [NREQ*NFLAGS-1:0]  req_flags;

  logic                    out_valid;
  logic                    out_ready;
  logic [FLEN-1:0]         out_data;
  logic [RDW-1:0]          out_rd;
  logic [$clog2(NREQ)-1:0] out_src;
  logic [NFLAGS-1:0]       out_flags;

  modport master (
    output req_valid, req_result, req_fmt, req_rd, req_flags, out_ready,
    input  req_ready, out_valid, out_data, out_rd, out_src, out_flags
  );

  modport slave (
    input  req_valid, req_result, req_fmt, req_rd, req_flags, out_ready,
    output req_ready, out_valid, out_data, out_rd, out_src, out_flags
  );

endinterface

// File: rtl/fpu_wb_arbiter_rr_arb.sv
// Round-robin grant generator: first valid at or above ptr, wrapping at NREQ.
module rr_arb import fpu_wb_pkg::*; #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PTRW-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PTRW-1:0] idx
);

  logic            found;
  logic [PTRW-1:0] cand;

  function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PTRW'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr, k);
      if (en && !found && valid[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Shares the FP pack path and regfile write port between NREQ producers;
// one registered output entry plus sticky exception flags.
module fpu_wb_arbiter import fpu_wb_pkg::*; #(
  parameter int NREQ = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  fpu_wb_arbiter_if.slave         bus,
  input  logic                    flush,
  input  logic                    flags_clr,
  output logic [NFLAGS-1:0]       sticky_flags
);

  localparam int SRCW = $clog2(NREQ);

  logic              out_valid_q, out_valid_d;
  wb_entry_t         ent_q, ent_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [NFLAGS-1:0] sticky_q, sticky_d;

  logic              can_accept;
  logic              retire;
  logic [NREQ-1:0]   gnt;
  logic [PTRW-1:0]   gnt_idx;

  logic [FLEN-1:0]    sel_result;
  logic [FMTBITS-1:0] sel_fmt;
  logic [RDW-1:0]     sel_rd;
  logic [NFLAGS-1:0]  sel_flags;

  assign can_accept = !flush && (!out_valid_q || bus.out_ready);
  assign retire     = out_valid_q && bus.out_ready && !flush;

  // reset_n gates the enable so no producer sees ready while reset is held.
  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .en    (can_accept && reset_n),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    sel_result = '0;
    sel_fmt    = '0;
    sel_rd     = '0;
    sel_flags  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_result = bus.req_result[i*FLEN +: FLEN];
        sel_fmt    = bus.req_fmt[i*FMTBITS +: FMTBITS];
        sel_rd     = bus.req_rd[i*RDW +: RDW];
        sel_flags  = bus.req_flags[i*NFLAGS +: NFLAGS];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ent_d       = ent_q;
    ptr_d       = ptr_q;
    sticky_d    = sticky_q;

    if (flags_clr) sticky_d = '0;
    // A retire in the same cycle as a clear still lands in the fresh sticky set.
    if (retire) sticky_d = (flags_clr ? '0 : sticky_q) | ent_q.flags;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (|gnt) begin
      out_valid_d = 1'b1;
      ent_d.data  = fp_pack(sel_result, sel_fmt);
      ent_d.rd    = sel_rd;
      ent_d.src   = gnt_idx;
      ent_d.flags = sel_flags;
      ptr_d       = rr_next(gnt_idx, NREQ);
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      ent_q       <= '0;
      ptr_q       <= '0;
      sticky_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ent_q       <= ent_d;
      ptr_q       <= ptr_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = ent_q.data;
  assign bus.out_rd    = ent_q.rd;
  assign bus.out_src   = ent_q.src[SRCW-1:0];
  assign bus.out_flags = ent_q.flags;
  assign sticky_flags  = sticky_q;

endmodule

// File: doc/fpu_wb_arbiter.md
Name: fpu_wb_arbiter

Overview:
- Shares one FPU result-packing path (NaN-boxing to FLEN) and one FP register-file write port between NREQ result producers: 0 = FMA/add, 1 = div/sqrt, 2 = convert/misc.
- Round-robin arbitration with valid/ready handshakes feeds a one-entry registered output stage toward writeback.
- Accumulates a sticky copy of retired exception flags for fflags/CSR update.

Parameters:
- NREQ, 3, number of result producers; fixed range 2..4.
- FLEN, from config package, unpacked/packed result width.
- FMTBITS, from config package, format selector width.
- RDW, 5, destination register index width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  producer i has a result
- req_ready  out  NREQ  producer i result accepted this cycle
- req_result  in  NREQ*FLEN  unpacked results, producer i at slice i
- req_fmt  in  NREQ*FMTBITS  result formats
- req_rd  in  NREQ*RDW  destination registers
- req_flags  in  NREQ*5  exception flags {NV,DZ,OF,UF,NX}
- flush  in  1  pipeline flush
- out_valid  out  1  packed result valid
- out_ready  in  1  regfile write port accepts
- out_data  out  FLEN  packed, NaN-boxed result
- out_rd  out  RDW  destination register
- out_src  out  $clog2(NREQ)  index of the granting producer
- out_flags  out  5  flags of the output result
- flags_clr  in  1  clear sticky flags
- sticky_flags  out  5  OR of flags of all retired results since the last clear

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid = 0; out_data, out_rd, out_src, out_flags = 0.
  - sticky_flags = 0; rr pointer = 0 (producer 0 highest priority).
  - req_ready = 0 while reset_n is low.
  - Reset mid-transaction drops the held output entry; no retirement occurs.
- can_accept = !flush && (!out_valid || out_ready).
- Grant is combinational:
  - Only when can_accept is true.
  - Grant goes to the first asserted req_valid, searching from rr pointer upward with wrap-around (NREQ-1 wraps to 0).
  - Exactly one req_ready bit is high when a grant occurs; all are low otherwise.
  - req_ready never depends on req_valid of the same producer beyond the grant itself, so a producer cannot form a combinational loop.
- Producer rule: hold valid and data stable until ready. Dropping valid without a handshake is legal only on flush.
- Transfer: req_valid[i] && req_ready[i] at cycle N means that at cycle N+1:
  - out_valid = 1; out_data = pack(req_result[i], req_fmt[i]); out_rd, out_flags and out_src = i are registered.
  - Latency is exactly 1 cycle.
- Pack rule:
  - Full-precision format: passes through unchanged.
  - Narrower format: {sign, exp MSB, exp low bits, fraction MSBs}, upper bits filled with 1s (NaN-boxing).
- rr pointer: after a grant to i, pointer = (i+1) mod NREQ. Unchanged when there is no grant.
- Output stage:
  - out_valid && !out_ready: hold all out_* stable; no grant.
  - out_valid && out_ready: the entry retires; a new grant in the same cycle is allowed (back-to-back, 1 result/cycle).
- Retire (out_valid && out_ready && !flush):
  - Normally sticky_flags |= out_flags.
  - If flags_clr is asserted the same cycle, sticky_flags = out_flags (clear, then the current retire still counts).
  - flags_clr alone: sticky_flags = 0.
- Flush:
  - No grant that cycle.
  - out_valid = 0 next cycle; the held entry is discarded and does not update sticky_flags.
  - rr pointer and sticky_flags are unchanged.
- out_rd = 0 is passed through unchanged; the FP register file has no hard-wired zero.

Decomposition:
- Shared package (fpu_wb_pkg):
  - Flag bit indices.
  - Typedef wb_entry_t {data, rd, src, flags}.
  - Function rr_next(ptr).
- Sub-module rr_arb: NREQ-wide round-robin grant generator.
  - Inputs: valid vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
- Packing uses the existing FPU pack unit, instantiated once behind the grant mux.

Test Plan (RV64D config: FLEN=64, FMTBITS=1, Fmt 0=single, 1=double):
- Single-result NaN-box:
  - Stimulus: req_valid=3'b001, result 0x3FF0000000000000, fmt=0, rd=7, flags=0, out_ready=1.
  - Response: next cycle out_valid=1, out_data=0xFFFFFFFF3F800000, out_rd=7, out_src=0.
- Round-robin fairness:
  - Stimulus: all three valid continuously, out_ready=1.
  - Response: grant order 0,1,2,0,1,2; one result per cycle; no gaps.
- Backpressure:
  - Stimulus: out_valid=1, out_ready=0 for 4 cycles, req_valid=3'b010.
  - Response: req_ready=0 and out_* stable all 4 cycles; out_ready=1 then retires the entry and grants producer 1 in the same cycle.
- Sticky flags:
  - Stimulus: retire flags 5'b00001, then 5'b10000; then flags_clr with a retire of 5'b00100.
  - Response: sticky_flags = 5'b00001, then 5'b10001, then 5'b00100.
- Flush:
  - Stimulus: out_valid=1 holding flags 5'b01000, flush=1, out_ready=1.
  - Response: next cycle out_valid=0; sticky_flags unchanged; no req_ready that cycle; pointer unchanged.
- Reset mid-stall:
  - Stimulus: assert reset_n=0 asynchronously while out_valid=1.
  - Response: out_valid=0 immediately, sticky_flags=0, all req_ready=0; after release, producer 0 has first priority.
